// File: rtl/module_pipelined_cla_adder.sv
// Pipelined, segmented carry look-ahead adder/subtractor.
// One SEG_W-bit CLA per stage; the inter-segment carry is registered.
module module_pipelined_cla_adder #(
  parameter int CLA_WIDTH  = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [CLA_WIDTH-1:0] a_i,
  input  logic [CLA_WIDTH-1:0] b_i,
  input  logic                 carry_i,
  input  logic                 sub_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CLA_WIDTH-1:0] sum_o,
  output logic                 carry_o,
  output logic                 overflow_o
);

  localparam int W     = CLA_WIDTH;
  localparam int SEG_W = CLA_WIDTH / NUM_STAGES;

  logic         stall;
  logic [W-1:0] b_eff;

  logic [W-1:0] a_s   [NUM_STAGES];
  logic [W-1:0] b_s   [NUM_STAGES];
  logic [W-1:0] sum_s [NUM_STAGES];
  logic         c_s   [NUM_STAGES];
  logic         sub_s [NUM_STAGES];
  logic         sa_s  [NUM_STAGES];
  logic         sb_s  [NUM_STAGES];
  logic         v_s   [NUM_STAGES];

  assign stall   = valid_o & ~ready_i;
  assign ready_o = ~stall;

  assign b_eff    = sub_i ? ~b_i : b_i;
  assign a_s[0]   = a_i;
  assign b_s[0]   = b_eff;
  assign sum_s[0] = '0;
  assign c_s[0]   = sub_i ^ carry_i;
  assign sub_s[0] = sub_i;
  assign sa_s[0]  = a_i[W-1];
  assign sb_s[0]  = b_eff[W-1];
  assign v_s[0]   = valid_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [SEG_W-1:0] x;
    logic [SEG_W-1:0] y;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] s;
    logic [SEG_W:0]   c;
    logic [W-1:0]     sum_n;
    logic             acc;
    logic             pp;

    assign x = a_s[k][SEG_W-1:0];
    assign y = b_s[k][SEG_W-1:0];
    assign g = x & y;
    assign p = x ^ y;

    // Each carry is a flat generate/propagate product of the segment carry-in.
    always_comb begin
      acc  = 1'b0;
      pp   = 1'b0;
      c    = '0;
      c[0] = c_s[k];
      for (int i = 0; i < SEG_W; i++) begin
        acc = g[i];
        pp  = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          acc = acc | (pp & g[j]);
          pp  = pp & p[j];
        end
        c[i+1] = acc | (pp & c_s[k]);
      end
    end

    assign s     = p ^ c[SEG_W-1:0];
    assign sum_n = sum_s[k] | (W'(s) << (k * SEG_W));

    if (k < NUM_STAGES - 1) begin : g_mid
      logic [W-1:0] a_r;
      logic [W-1:0] b_r;
      logic [W-1:0] sum_r;
      logic         c_r;
      logic         sub_r;
      logic         sa_r;
      logic         sb_r;
      logic         v_r;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          a_r   <= '0;
          b_r   <= '0;
          sum_r <= '0;
          c_r   <= 1'b0;
          sub_r <= 1'b0;
          sa_r  <= 1'b0;
          sb_r  <= 1'b0;
          v_r   <= 1'b0;
        end else if (!stall) begin
          a_r   <= a_s[k] >> SEG_W;
          b_r   <= b_s[k] >> SEG_W;
          sum_r <= sum_n;
          c_r   <= c[SEG_W];
          sub_r <= sub_s[k];
          sa_r  <= sa_s[k];
          sb_r  <= sb_s[k];
          v_r   <= v_s[k];
        end
      end

      assign a_s[k+1]   = a_r;
      assign b_s[k+1]   = b_r;
      assign sum_s[k+1] = sum_r;
      assign c_s[k+1]   = c_r;
      assign sub_s[k+1] = sub_r;
      assign sa_s[k+1]  = sa_r;
      assign sb_s[k+1]  = sb_r;
      assign v_s[k+1]   = v_r;
    end else begin : g_last
      logic [W-1:0] sum_r;
      logic         cout_r;
      logic         ov_r;
      logic         v_r;
      logic         unused_hi;

      // Only the lowest segment of the last stage operands is consumed.
      assign unused_hi = ^{a_s[k], b_s[k]};

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sum_r  <= '0;
          cout_r <= 1'b0;
          ov_r   <= 1'b0;
          v_r    <= 1'b0;
        end else if (!stall) begin
          sum_r  <= sum_n;
          cout_r <= c[SEG_W] ^ sub_s[k];
          ov_r   <= (sa_s[k] == sb_s[k]) && (s[SEG_W-1] != sa_s[k]);
          v_r    <= v_s[k];
        end
      end

      assign sum_o      = sum_r;
      assign carry_o    = cout_r;
      assign overflow_o = ov_r;
      assign valid_o    = v_r;
    end
  end

endmodule

// File: tb/tb_module_pipelined_cla_adder.sv
// Scoreboard bench for the pipelined CLA adder/subtractor.
// Checks three configurations against an arithmetic reference model.
module tb_module_pipelined_cla_adder;

  typedef struct {
    longint sum;
    bit     c;
    bit     ov;
    int     acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // main DUT: 32 bits, 4 stages
  logic        rst, v_i, r_o, cin, sub, v_o, r_i, cout, ov;
  logic [31:0] a, b, sum;

  module_pipelined_cla_adder #(.CLA_WIDTH(32), .NUM_STAGES(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(v_i), .ready_o(r_o),
    .a_i(a), .b_i(b), .carry_i(cin), .sub_i(sub),
    .valid_o(v_o), .ready_i(r_i), .sum_o(sum),
    .carry_o(cout), .overflow_o(ov)
  );

  // aux DUTs: 32 bits / 1 stage, 16 bits / 2 stages
  logic        rst2;
  logic        x1v_i, x1r_o, x1cin, x1sub, x1v_o, x1r_i, x1cout, x1ov;
  logic [31:0] x1a, x1b, x1sum;
  logic        x2v_i, x2r_o, x2cin, x2sub, x2v_o, x2r_i, x2cout, x2ov;
  logic [15:0] x2a, x2b, x2sum;

  module_pipelined_cla_adder #(.CLA_WIDTH(32), .NUM_STAGES(1)) dut1 (
    .clk_i(clk), .rst_i(rst2), .valid_i(x1v_i), .ready_o(x1r_o),
    .a_i(x1a), .b_i(x1b), .carry_i(x1cin), .sub_i(x1sub),
    .valid_o(x1v_o), .ready_i(x1r_i), .sum_o(x1sum),
    .carry_o(x1cout), .overflow_o(x1ov)
  );

  module_pipelined_cla_adder #(.CLA_WIDTH(16), .NUM_STAGES(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .valid_i(x2v_i), .ready_o(x2r_o),
    .a_i(x2a), .b_i(x2b), .carry_i(x2cin), .sub_i(x2sub),
    .valid_o(x2v_o), .ready_i(x2r_i), .sum_o(x2sum),
    .carry_o(x2cout), .overflow_o(x2ov)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, want none", nm);
  endtask

  // Integer arithmetic: {carry, sum} = A +/- B +/- cin, overflow = out of signed range.
  function automatic exp_t model(input int w, input longint ua, input longint ub,
                                 input bit ci, input bit sb, input int acc);
    exp_t   r;
    longint m, h, ur, sa, sbv, sr, c;
    m   = longint'(1) << w;
    h   = m / 2;
    c   = ci ? 1 : 0;
    ur  = sb ? ua - ub - c : ua + ub + c;
    sa  = (ua >= h) ? ua - m : ua;
    sbv = (ub >= h) ? ub - m : ub;
    sr  = sb ? sa - sbv - c : sa + sbv + c;
    r.sum = ur & (m - 1);
    r.c   = sb ? (ur < 0) : (ur >= m);
    r.ov  = (sr < -h) || (sr >= h);
    r.acc = acc;
    return r;
  endfunction

  // ---------------- main scoreboard ----------------
  exp_t        q[$];
  bit          lat_check = 1'b0;
  bit          head_seen = 1'b0;
  int          n_out = 0;
  bit          held = 1'b0;
  logic [31:0] h_sum;
  logic        h_c, h_ov;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      head_seen = 1'b0;
      held = 1'b0;
    end else begin
      if (v_i && r_o)
        q.push_back(model(32, a, b, cin, sub, cyc + 1));
      check("ready_o", r_o, !(v_o && !r_i));
      if (held) begin
        check("stall_valid", v_o, 1);
        check("stall_sum", sum, h_sum);
        check("stall_carry", cout, h_c);
        check("stall_ovf", ov, h_ov);
      end
      if (v_o) begin
        if (q.size() == 0) begin
          flag_fail("unexpected_valid");
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            if (lat_check) check("latency", cyc - q[0].acc, 3);
          end
          if (r_i) begin
            exp_t e;
            e = q.pop_front();
            check("sum", sum, e.sum);
            check("carry", cout, e.c);
            check("overflow", ov, e.ov);
            head_seen = 1'b0;
            n_out++;
          end
        end
      end
      held  = v_o && !r_i;
      h_sum = sum;
      h_c   = cout;
      h_ov  = ov;
    end
  end

  // ---------------- aux scoreboards ----------------
  exp_t q1[$];
  exp_t q2[$];
  int   n1_out = 0;
  int   n2_out = 0;
  bit   aux_done = 1'b0;

  always @(negedge clk) begin
    if (rst2) begin
      q1.delete();
      q2.delete();
    end else begin
      if (x1v_o) begin
        if (q1.size() == 0) flag_fail("unexpected_valid_n1");
        else begin
          exp_t e;
          e = q1.pop_front();
          check("n1_latency", cyc - e.acc, 0);
          check("n1_sum", x1sum, e.sum);
          check("n1_carry", x1cout, e.c);
          check("n1_overflow", x1ov, e.ov);
          n1_out++;
        end
      end
      if (x2v_o) begin
        if (q2.size() == 0) flag_fail("unexpected_valid_w16");
        else begin
          exp_t e;
          e = q2.pop_front();
          check("w16_latency", cyc - e.acc, 1);
          check("w16_sum", x2sum, e.sum);
          check("w16_carry", x2cout, e.c);
          check("w16_overflow", x2ov, e.ov);
          n2_out++;
        end
      end
      if (x1v_i && x1r_o) q1.push_back(model(32, x1a, x1b, x1cin, x1sub, cyc + 1));
      if (x2v_i && x2r_o) q2.push_back(model(16, x2a, x2b, x2cin, x2sub, cyc + 1));
    end
  end

  initial begin
    rst2 = 1'b1;
    x1v_i = 1'b0; x1r_i = 1'b1; x1a = '0; x1b = '0; x1cin = 1'b0; x1sub = 1'b0;
    x2v_i = 1'b0; x2r_i = 1'b1; x2a = '0; x2b = '0; x2cin = 1'b0; x2sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      x1v_i = 1'b1; x1a = $urandom; x1b = $urandom;
      x1cin = 1'($urandom_range(0, 1)); x1sub = 1'($urandom_range(0, 1));
      x2v_i = 1'b1; x2a = 16'($urandom); x2b = 16'($urandom);
      x2cin = 1'($urandom_range(0, 1)); x2sub = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    x1v_i = 1'b0;
    x2v_i = 1'b0;
    repeat (6) @(posedge clk);
    aux_done = 1'b1;
  end

  // ---------------- main stimulus ----------------
  task automatic load_random();
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic directed(input string nm, input logic [31:0] da, input logic [31:0] db,
                          input logic dc, input logic ds, input logic [31:0] es,
                          input logic ec, input logic eo);
    bit seen;
    @(posedge clk); #1;
    a = da; b = db; cin = dc; sub = ds; v_i = 1'b1; r_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (v_o) seen = 1'b1;
    end
    if (!seen) flag_fail({nm, "_timeout"});
    else begin
      check({nm, "_sum"}, sum, es);
      check({nm, "_carry"}, cout, ec);
      check({nm, "_ovf"}, ov, eo);
    end
    @(posedge clk);
  endtask

  task automatic drain(input string nm);
    @(posedge clk); #1;
    v_i = 1'b0;
    r_i = 1'b1;
    for (int k = 0; k < 30 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check({nm, "_drained"}, q.size(), 0);
  endtask

  initial begin
    int  idx, sent, base;
    bit  acc;
    rst = 1'b1; v_i = 1'b0; r_i = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    check("in_reset_valid", v_o, 0);
    check("in_reset_sum", sum, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", v_o, 0);
    check("rst_ready", r_o, 1);
    check("rst_sum", sum, 0);
    check("rst_carry", cout, 0);
    check("rst_ovf", ov, 0);

    lat_check = 1'b1;
    directed("t1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    directed("t2a", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("t2b", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    directed("t3a", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    directed("t3b", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b0, 1'b0);
    lat_check = 1'b0;

    // back-to-back stream with a 3-cycle downstream stall
    base = n_out;
    idx = 0;
    @(posedge clk); #1;
    load_random();
    v_i = 1'b1;
    r_i = 1'b1;
    for (int t = 0; t < 100 && idx < 8; t++) begin
      @(negedge clk);
      acc = r_o;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 8) load_random();
        else v_i = 1'b0;
      end
      r_i = !(t >= 4 && t < 7);
    end
    drain("stream");
    check("stream_count", n_out - base, 8);

    // asynchronous reset with three ops in flight
    @(posedge clk); #1;
    r_i = 1'b0; v_i = 1'b1; a = 32'h1234; b = 32'h1; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 32'h10; b = 32'h20;
    @(posedge clk); #1;
    a = 32'h100; b = 32'h200;
    @(posedge clk); #1;
    v_i = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", v_o, 1);
    #1 rst = 1'b1;
    #1;
    check("async_valid", v_o, 0);
    check("async_sum", sum, 0);
    check("async_carry", cout, 0);
    check("async_ovf", ov, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r_i = 1'b1;
    repeat (8) @(posedge clk);
    lat_check = 1'b1;
    directed("post_reset", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);
    lat_check = 1'b0;

    // random valid / ready traffic
    base = n_out;
    sent = 0;
    @(posedge clk); #1;
    load_random();
    v_i = 1'b1;
    for (int t = 0; t < 5000 && sent < 200; t++) begin
      @(negedge clk);
      acc = v_i && r_o;
      if (acc) sent++;
      @(posedge clk); #1;
      if (acc || !v_i) begin
        load_random();
        v_i = ($urandom_range(0, 3) != 0) && (sent < 200);
      end
      r_i = ($urandom_range(0, 3) != 0);
    end
    drain("random");
    check("random_count", n_out - base, 200);

    for (int k = 0; k < 2000 && !aux_done; k++) @(posedge clk);
    if (!aux_done) flag_fail("aux_timeout");
    check("n1_count", n1_out, 200);
    check("w16_count", n2_out, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
